// File: rtl/aria_wr_buf.sv
// aria_wr_buf: host-to-core write buffer; packs 32-bit host words into zero-padded
// big-endian 128-bit blocks and hands them to the cipher datapath over valid/ready.
module aria_wr_buf #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_core,
    input  logic          wb_en,
    input  logic [15:0]   cmd_extend,
    input  logic [1:0]    wb_op,
    input  logic          wr_en,
    input  logic [31:0]   wr_d,
    output logic          wr_full,
    output logic          wr_ovf,
    output logic [AW:0]   fifo_lvl,
    output logic [1:0]    wb_op_q,
    output logic [127:0]  wb_do,
    output logic          wb_d_vld,
    input  logic          wb_d_rdy,
    output logic          wb_last,
    output logic          wb_done
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   lvl;
    logic [15:0]   cnt;
    logic [127:0]  blk;
    logic [1:0]    st, idx;
    logic [4:0]    b_q, nb, end_b;
    logic          ovf, push, pop, last_w, cmd_last;
    logic [31:0]   mask;

    // Level never exceeds the depth, so its MSB alone means full.
    assign wr_full  = lvl[AW];
    assign push     = wr_en && !wr_full;
    assign pop      = st == LOAD && lvl != '0;
    assign nb       = cnt > 16'd16 ? 5'd16 : cnt[4:0];
    assign end_b    = {1'b0, idx, 2'b00} + 5'd4;
    assign last_w   = end_b >= b_q;
    assign cmd_last = cnt <= 16'd16;
    assign mask     = (!last_w || b_q[1:0] == 2'd0) ? 32'hFFFF_FFFF :
                      b_q[1:0] == 2'd1 ? 32'hFF00_0000 :
                      b_q[1:0] == 2'd2 ? 32'hFFFF_0000 : 32'hFFFF_FF00;

    assign wr_ovf   = ovf;
    assign fifo_lvl = lvl;
    assign wb_do    = blk;
    assign wb_d_vld = st == PRESENT;
    assign wb_last  = st == PRESENT && cmd_last;
    assign wb_done  = st == IDLE && cnt == 16'd0;

    always_ff @(posedge clk) begin
        if (push && !clr_core && !wb_en)
            mem[wr_ptr] <= wr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wb_op_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lvl     <= '0;
            ovf     <= 1'b0;
            blk     <= '0;
            idx     <= '0;
            b_q     <= '0;
            st      <= IDLE;
        end else if (clr_core) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
            blk    <= '0;
            idx    <= '0;
            st     <= IDLE;
        end else if (wb_en) begin
            cnt     <= cmd_extend;
            wb_op_q <= wb_op;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lvl     <= '0;
            ovf     <= 1'b0;
            blk     <= '0;
            idx     <= '0;
            st      <= IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && wr_full)
                ovf <= 1'b1;
            if (push && !pop)
                lvl <= lvl + (AW+1)'(1);
            else if (!push && pop)
                lvl <= lvl - (AW+1)'(1);
            case (st)
                IDLE: begin
                    if (cnt != 16'd0 && lvl != '0) begin
                        blk <= '0;
                        idx <= '0;
                        b_q <= nb;
                        st  <= LOAD;
                    end
                end
                LOAD: begin
                    if (pop) begin
                        blk[{~idx, 5'd0} +: 32] <= mem[rd_ptr] & mask;
                        idx <= idx + 2'd1;
                        if (last_w)
                            st <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (wb_d_rdy) begin
                        cnt <= cmd_last ? 16'd0 : cnt - 16'd16;
                        st  <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aria_wr_buf.sv
// tb_aria_wr_buf: directed and randomized checks of aria_wr_buf against a
// block-level reference model built from the command byte count and host words.
module tb_aria_wr_buf;
    logic         clk = 0, rst_n = 0, clr_core = 0, wb_en = 0, wr_en = 0, wb_d_rdy = 0;
    logic [15:0]  cmd_extend = 0;
    logic [1:0]   wb_op = 0;
    logic [31:0]  wr_d = 0;
    logic         wr_full, wr_ovf, wb_d_vld, wb_last, wb_done;
    logic [8:0]   fifo_lvl;
    logic [1:0]   wb_op_q;
    logic [127:0] wb_do;
    logic         s_full, s_ovf, s_vld, s_last, s_done;
    logic [2:0]   s_lvl;
    logic [1:0]   s_op_q;
    logic [127:0] s_do;

    aria_wr_buf #(.AW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr_core(clr_core), .wb_en(wb_en),
        .cmd_extend(cmd_extend), .wb_op(wb_op), .wr_en(wr_en), .wr_d(wr_d),
        .wr_full(wr_full), .wr_ovf(wr_ovf), .fifo_lvl(fifo_lvl), .wb_op_q(wb_op_q),
        .wb_do(wb_do), .wb_d_vld(wb_d_vld), .wb_d_rdy(wb_d_rdy), .wb_last(wb_last),
        .wb_done(wb_done)
    );

    aria_wr_buf #(.AW(2)) u_small (
        .clk(clk), .rst_n(rst_n), .clr_core(clr_core), .wb_en(wb_en),
        .cmd_extend(cmd_extend), .wb_op(wb_op), .wr_en(wr_en), .wr_d(wr_d),
        .wr_full(s_full), .wr_ovf(s_ovf), .fifo_lvl(s_lvl), .wb_op_q(s_op_q),
        .wb_do(s_do), .wb_d_vld(s_vld), .wb_d_rdy(wb_d_rdy), .wb_last(s_last),
        .wb_done(s_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [127:0] d;
    } blk_t;

    int           total = 0, bad = 0;
    blk_t         exp_q[$];
    logic [127:0] rx_q[$];
    logic [31:0]  wq[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: carve the byte count into 16-byte blocks consuming words from wq in order.
    task automatic build(input logic [15:0] c);
        int rem = int'(c), p = 0, b, n, r;
        logic [127:0] d;
        logic [31:0] w;
        blk_t e;
        exp_q.delete();
        while (rem > 0) begin
            b = rem > 16 ? 16 : rem;
            n = (b + 3) / 4;
            r = b % 4;
            d = '0;
            for (int i = 0; i < n; i++) begin
                w = wq[p + i];
                if (i == n - 1 && r != 0) w = w & ~(32'hFFFF_FFFF >> (8 * r));
                d = d | (128'(w) << (32 * (3 - i)));
            end
            e.last = rem <= 16;
            e.d = d;
            exp_q.push_back(e);
            p += n;
            rem = rem <= 16 ? 0 : rem - 16;
        end
    endtask

    task automatic run_cmd(input logic [15:0] c, input logic [1:0] op, input int stall_in, input bit rnd);
        int wi = 0, stall = stall_in, cyc = 0, need = (int'(c) + 3) / 4;
        bit pv = 0, prdy = 0, pl = 0;
        logic [127:0] pdo = '0;
        blk_t e;
        build(c);
        rx_q.delete();
        wb_en = 1; cmd_extend = c; wb_op = op;
        tick;
        wb_en = 0;
        chk("op_q", wb_op_q, op);
        chk("lvl_clr", fifo_lvl, 0);
        chk("done_lo", wb_done, 0);
        while ((exp_q.size() != 0 || wi < wq.size()) && cyc < 3000) begin
            if (pv && !prdy) begin
                chk("hold_vld", wb_d_vld, 1);
                chk("hold_do", wb_do, pdo);
                chk("hold_last", wb_last, pl);
            end
            if (stall > 0 && wb_d_vld) begin
                wb_d_rdy = 0;
                stall--;
            end else
                wb_d_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_en = wi < wq.size() && (!rnd || $urandom_range(0, 2) != 0);
            wr_d = wr_en ? wq[wi] : 32'h0;
            if (wr_en) wi++;
            if (wb_d_vld && wb_d_rdy) begin
                if (exp_q.size() == 0)
                    chk("extra_blk", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("blk", wb_do, e.d);
                    chk("last", wb_last, e.last);
                end
                rx_q.push_back(wb_do);
            end
            pv = wb_d_vld; prdy = wb_d_rdy; pdo = wb_do; pl = wb_last;
            tick;
            cyc++;
        end
        wr_en = 0; wb_d_rdy = 0;
        chk("timeout", exp_q.size(), 0);
        tick;
        chk("done", wb_done, 1);
        chk("vld_end", wb_d_vld, 0);
        chk("lvl_left", fifo_lvl, wq.size() - need);
    endtask

    initial begin
        int k, n;
        logic [15:0] c;
        repeat (2) tick;
        chk("rst_done", wb_done, 1);
        chk("rst_vld", wb_d_vld, 0);
        chk("rst_lvl", fifo_lvl, 0);
        chk("rst_do", wb_do, 0);
        chk("rst_full", wr_full, 0);
        chk("rst_ovf", wr_ovf, 0);
        chk("rst_last", wb_last, 0);
        chk("rst_op", wb_op_q, 0);
        chk("rst_s_done", s_done, 1);
        rst_n = 1;
        tick;

        wq = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        run_cmd(16, 2'd1, 0, 0);
        chk("t16_n", rx_q.size(), 1);
        chk("t16_blk", rx_q[0], 128'h000102030405060708090A0B0C0D0E0F);

        wq = '{32'hAABBCCDD, 32'h11223344};
        run_cmd(6, 2'd2, 0, 0);
        chk("t6_blk", rx_q[0], 128'hAABBCCDD_11220000_00000000_00000000);

        wq.delete();
        for (int i = 0; i < 9; i++) wq.push_back(32'hA5000100 + 32'(i));
        run_cmd(36, 2'd3, 5, 0);
        chk("t36_n", rx_q.size(), 3);
        chk("t36_b3", rx_q[2], {32'hA5000108, 96'h0});

        wb_en = 1; cmd_extend = 0; wb_op = 0;
        tick;
        wb_en = 0;
        chk("s_full0", s_full, 0);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_d = 32'(i);
            tick;
            if (i == 3) begin
                chk("s_full4", s_full, 1);
                chk("s_lvl4", s_lvl, 4);
                chk("s_ovf4", s_ovf, 0);
            end
        end
        wr_en = 0;
        chk("s_ovf5", s_ovf, 1);
        chk("s_lvl5", s_lvl, 4);
        chk("s_idle", s_vld, 0);
        wb_en = 1;
        tick;
        wb_en = 0;
        chk("s_ovf_clr", s_ovf, 0);
        chk("s_lvl_clr", s_lvl, 0);
        chk("s_full_clr", s_full, 0);

        wb_en = 1; cmd_extend = 32; wb_op = 2'd2;
        tick;
        wb_en = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_d = 32'hC0DE0000 + 32'(i);
            tick;
        end
        wr_en = 0;
        chk("mid_load_vld", wb_d_vld, 0);
        chk("mid_load_lvl", fifo_lvl, 2);
        wb_en = 1;
        tick;
        wb_en = 0;
        chk("abort_vld", wb_d_vld, 0);
        chk("abort_lvl", fifo_lvl, 0);
        chk("abort_done", wb_done, 0);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_d = 32'h5A000000 + 32'(i);
            tick;
        end
        wr_en = 0;
        k = 0;
        while (!wb_d_vld && k < 20) begin
            tick;
            k++;
        end
        chk("pres_vld", wb_d_vld, 1);
        chk("pres_do", wb_do, 128'h5A000000_5A000001_5A000002_5A000003);
        chk("pres_last", wb_last, 0);
        clr_core = 1;
        tick;
        clr_core = 0;
        chk("clr_vld", wb_d_vld, 0);
        chk("clr_done", wb_done, 1);
        chk("clr_lvl", fifo_lvl, 0);
        chk("clr_op", wb_op_q, 2);

        repeat (12) begin
            c = 16'($urandom_range(1, 80));
            n = (int'(c) + 3) / 4 + int'($urandom_range(0, 3));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_cmd(c, 2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aria_wr_buf.md
Name: aria_wr_buf

Overview:
- Host-to-core write buffer for the ARIA engine; the mirror of the read path.
- Host pushes 32-bit words into an internal FIFO. The block packs them into 128-bit blocks, big-endian (first word in bits [127:96]), and offers each block to the cipher datapath over a valid/ready handshake.
- A command-supplied byte count controls termination. The final partial block is zero-padded.

Parameters:
- AW, 8, FIFO address width; FIFO depth = 2**AW 32-bit words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- clr_core  in  1  synchronous core clear; highest priority after reset
- wb_en  in  1  1-cycle command start; loads byte count and op, flushes FIFO
- cmd_extend  in  16  total byte count for the command
- wb_op  in  2  operation code, latched on wb_en
- wr_en  in  1  host write strobe
- wr_d  in  32  host write data
- wr_full  out  1  FIFO full
- wr_ovf  out  1  sticky overflow flag
- fifo_lvl  out  AW+1  current FIFO occupancy
- wb_op_q  out  2  latched op
- wb_do  out  128  assembled block
- wb_d_vld  out  1  block valid
- wb_d_rdy  in  1  consumer ready
- wb_last  out  1  qualifies wb_d_vld; marks the block that exhausts the byte count
- wb_done  out  1  level: command complete (IDLE and count == 0)

Behaviour:
- Reset values:
  - all registers 0; state IDLE.
  - wb_do = 0, wb_d_vld = 0, wb_last = 0, wr_full = 0, wr_ovf = 0, fifo_lvl = 0, wb_op_q = 0.
  - wb_done = 1 (count 0 in IDLE).
- Priority each cycle: clr_core > wb_en > normal operation.
  - clr_core: count=0, FIFO pointers/level=0, wr_ovf=0, buffer=0, state=IDLE. wb_op_q is held.
  - wb_en: count=cmd_extend, wb_op_q=wb_op, FIFO pointers/level=0, wr_ovf=0, buffer=0, state=IDLE. A wr_en in the same cycle is dropped.
- FIFO:
  - Write accepted iff wr_en and not full. Full is evaluated before any same-cycle pop, so a write at full is dropped even if a pop occurs.
  - A dropped write sets wr_ovf (sticky until clr_core or wb_en).
  - Pop iff the state machine requests it and level != 0.
  - Read data is the combinational mem[rd_ptr] (fall-through).
  - Pointers wrap modulo 2**AW. Level increments on write only, decrements on pop only, and is unchanged on simultaneous write and pop.
- Block sizing, computed in IDLE from count C:
  - bytes B = min(C,16); words needed N = ceil(B/4), range 1..4.
  - The last needed word keeps only the first (B mod 4) bytes when B mod 4 != 0. Byte 0 is bits [31:24]; the remaining low bytes are forced to 0.
  - Unfilled word slots are 0.
- State machine:
  - IDLE:
    - If count==0: wb_done=1 and stay.
    - Else if level!=0: clear buffer and slot index, latch N and B, go to LOAD.
  - LOAD:
    - Each cycle with level!=0: pop, write the masked word into slot idx (bits [127-32*idx -: 32]), idx++.
    - When the popped word is slot N-1, go to PRESENT.
    - Empty FIFO stalls in LOAD with no pop.
  - PRESENT:
    - wb_d_vld=1; wb_do=buffer; wb_last=1 iff C<=16.
    - On wb_d_rdy: count = (C<=16) ? 0 : C-16, then go to IDLE.
    - wb_do and wb_last are held stable while vld is high and rdy is low.
- Latency:
  - First pop occurs the cycle after IDLE sees non-empty.
  - With a full FIFO, wb_d_vld rises N+1 cycles after leaving IDLE.
- Excess words beyond the byte count remain in the FIFO and are discarded on the next wb_en or clr_core.
- wb_en asserted mid-block aborts the block immediately; wb_d_vld falls the next cycle.

Test Plan:
- Reset → wb_done=1, wb_d_vld=0, fifo_lvl=0, wb_do=0.
- wb_en with cmd_extend=16; write 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; rdy=1 → one block 0x000102030405060708090A0B0C0D0E0F, wb_last=1, then wb_done=1.
- cmd_extend=6; write 0xAABBCCDD, 0x11223344 → wb_do=0xAABBCCDD_11220000_00000000_00000000, wb_last=1.
- cmd_extend=36; write 9 words; hold rdy=0 for 5 cycles on block 1 → wb_do stable; blocks 1-2 have wb_last=0; block 3 = word9 masked, with wb_last=1.
- AW=2; 5 writes with no consumption → wr_full after 4, 5th dropped, wr_ovf=1, fifo_lvl=4; wb_en then clears wr_ovf and level.
- cmd_extend=32; wb_en asserted mid-LOAD, then clr_core mid-PRESENT → state IDLE, vld=0 next cycle, count reloaded/zeroed, and wb_done=1 after clr_core.
